// File: rtl/multi_channel_integrity_sb.sv
// Multi-channel data-integrity scoreboard: NUM_CH first-word-fall-through
// FIFOs behind one shared push port and one shared pop port, with a single
// magic-packet tracker that follows one tagged packet to its exit and checks it.
// Optional feature macro: SB_RECAPTURE_EN (re-arm after DONE, capture_count_o).
module multi_channel_integrity_sb #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CHWID  = $clog2(NUM_CH),
    parameter int unsigned CNTWID = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [CHWID-1:0]  push_ch_i,
    input  logic [WIDTH-1:0]  data_in_i,
    input  logic              pop_i,
    input  logic [CHWID-1:0]  pop_ch_i,
    input  logic              start_i,
    output logic [NUM_CH-1:0] full_o,
    output logic [NUM_CH-1:0] empty_o,
    output logic [WIDTH-1:0]  data_out_o,
    output logic              data_out_vld_o,
    output logic              prop_signal_o,
    output logic              err_sticky_o,
    output logic [1:0]        trk_state_o,
    output logic [CHWID-1:0]  trk_ch_o,
    output logic [CNTWID-1:0] trk_cnt_o
`ifdef SB_RECAPTURE_EN
    ,
    output logic [15:0]       capture_count_o
`endif
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } trk_state_e;

    logic [NUM_CH-1:0][DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [NUM_CH-1:0][PTRW-1:0]             wr_ptr_q;
    logic [NUM_CH-1:0][PTRW-1:0]             rd_ptr_q;
    logic [NUM_CH-1:0][CNTWID-1:0]           occ_q;

    trk_state_e        state_q, state_d;
    logic [WIDTH-1:0]  magic_q;
    logic [CHWID-1:0]  trk_ch_q;
    logic [CNTWID-1:0] trk_cnt_q;
    logic              err_q;
`ifdef SB_RECAPTURE_EN
    logic [15:0]       cap_cnt_q;
`endif

    logic [NUM_CH-1:0] push_en_c;
    logic [NUM_CH-1:0] pop_en_c;
    logic              push_acc_c;
    logic              pop_acc_c;
    logic              same_ch_c;
    logic [CNTWID-1:0] push_occ_c;
    logic [WIDTH-1:0]  data_out_c;
    logic              capture_c;
    logic              trk_pop_c;
    logic              trk_exit_c;

    // Wrap a FIFO pointer modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Per-channel full/empty flags from pre-edge occupancy.
    always_comb begin
        full_o  = '0;
        empty_o = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            full_o[c]  = (occ_q[c] == CNTWID'(DEPTH));
            empty_o[c] = (occ_q[c] == '0);
        end
    end

    // Request decode; channel indices >= NUM_CH match nothing and are rejected.
    always_comb begin
        push_en_c  = '0;
        pop_en_c   = '0;
        push_occ_c = '0;
        data_out_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (push_ch_i == CHWID'(c)) begin
                push_en_c[c] = push_i & ~full_o[c];
                push_occ_c   = occ_q[c];
            end
            if (pop_ch_i == CHWID'(c)) begin
                pop_en_c[c] = pop_i & ~empty_o[c];
                data_out_c  = mem_q[c][rd_ptr_q[c]];
            end
        end
        push_acc_c = |push_en_c;
        pop_acc_c  = |pop_en_c;
        same_ch_c  = (push_ch_i == pop_ch_i);
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (push_en_c[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
                if (pop_en_c[c])  rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
                occ_q[c] <= occ_q[c] + CNTWID'(push_en_c[c]) - CNTWID'(pop_en_c[c]);
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (push_en_c[c]) mem_q[c][wr_ptr_q[c]] <= data_in_i;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Tracker next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (capture_c)  state_d = ST_TRACK;
            ST_TRACK: if (trk_exit_c) state_d = ST_DONE;
`ifdef SB_RECAPTURE_EN
            ST_DONE:  state_d = ST_IDLE;
`else
            ST_DONE:  state_d = ST_DONE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Tracker outputs and strobes: capture, tracked-channel pop, exit check.
    always_comb begin
        capture_c      = (state_q == ST_IDLE) & start_i & push_acc_c;
        trk_pop_c      = (state_q == ST_TRACK) & pop_acc_c & (pop_ch_i == trk_ch_q);
        trk_exit_c     = trk_pop_c & (trk_cnt_q == CNTWID'(1));
        data_out_vld_o = trk_exit_c;
        prop_signal_o  = ~trk_exit_c | (data_out_c == magic_q);
    end

    // Tracker datapath: captured packet, position counter, sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            magic_q   <= '0;
            trk_ch_q  <= '0;
            trk_cnt_q <= '0;
            err_q     <= 1'b0;
`ifdef SB_RECAPTURE_EN
            cap_cnt_q <= '0;
`endif
        end else begin
            if (!prop_signal_o) err_q <= 1'b1;
            if (capture_c) begin
                magic_q   <= data_in_i;
                trk_ch_q  <= push_ch_i;
                trk_cnt_q <= push_occ_c + CNTWID'(1) - CNTWID'(pop_acc_c & same_ch_c);
`ifdef SB_RECAPTURE_EN
                if (cap_cnt_q != 16'hFFFF) cap_cnt_q <= cap_cnt_q + 16'd1;
`endif
            end else if (trk_pop_c) begin
                trk_cnt_q <= trk_cnt_q - CNTWID'(1);
            end
        end
    end

    assign data_out_o   = data_out_c;
    assign err_sticky_o = err_q;
    assign trk_state_o  = state_q;
    assign trk_ch_o     = trk_ch_q;
    assign trk_cnt_o    = trk_cnt_q;
`ifdef SB_RECAPTURE_EN
    assign capture_count_o = cap_cnt_q;
`endif

endmodule

// File: tb/tb_multi_channel_integrity_sb.sv
// Directed bench for multi_channel_integrity_sb (NUM_CH=2, DEPTH=8, WIDTH=8).
// Build with SB_RECAPTURE_EN defined to exercise the re-arm path.
module tb_multi_channel_integrity_sb;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CHWID  = 1;
    localparam int unsigned CNTWID = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push = 1'b0;
    logic [CHWID-1:0]  push_ch = '0;
    logic [WIDTH-1:0]  data_in = '0;
    logic              pop = 1'b0;
    logic [CHWID-1:0]  pop_ch = '0;
    logic              start = 1'b0;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [WIDTH-1:0]  data_out;
    logic              data_out_vld;
    logic              prop_signal;
    logic              err_sticky;
    logic [1:0]        trk_state;
    logic [CHWID-1:0]  trk_ch;
    logic [CNTWID-1:0] trk_cnt;
`ifdef SB_RECAPTURE_EN
    logic [15:0]       capture_count;
`endif

    logic [NUM_CH-1:0][DEPTH-1:0][WIDTH-1:0] mem_v;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_channel_integrity_sb #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .WIDTH(WIDTH), .CHWID(CHWID), .CNTWID(CNTWID)
    ) dut (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_ch_i(push_ch), .data_in_i(data_in),
        .pop_i(pop), .pop_ch_i(pop_ch), .start_i(start), .full_o(full), .empty_o(empty),
        .data_out_o(data_out), .data_out_vld_o(data_out_vld), .prop_signal_o(prop_signal),
        .err_sticky_o(err_sticky), .trk_state_o(trk_state), .trk_ch_o(trk_ch),
        .trk_cnt_o(trk_cnt)
`ifdef SB_RECAPTURE_EN
        , .capture_count_o(capture_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ps, input logic [CHWID-1:0] pc, input logic [WIDTH-1:0] d,
                         input logic pp, input logic [CHWID-1:0] qc, input logic st);
        push = ps; push_ch = pc; data_in = d; pop = pp; pop_ch = qc; start = st;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL rst_empty: got %b want 11", empty); end
        tests++; if (full !== 2'b00) begin fails++; $display("FAIL rst_full: got %b want 00", full); end
        tests++; if (trk_state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d want 0", trk_state); end
        tests++; if (trk_ch !== 1'b0) begin fails++; $display("FAIL rst_trk_ch: got %0d want 0", trk_ch); end
        tests++; if (trk_cnt !== 4'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", trk_cnt); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_sticky); end
        tests++; if (data_out_vld !== 1'b0) begin fails++; $display("FAIL rst_vld: got %b want 0", data_out_vld); end
        tests++; if (prop_signal !== 1'b1) begin fails++; $display("FAIL rst_prop: got %b want 1", prop_signal); end
    endtask

    task automatic test_single_capture();
        do_reset();
        drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        tick();
        tests++; if (trk_state !== 2'd1) begin fails++; $display("FAIL cap_state: got %0d want 1", trk_state); end
        tests++; if (trk_cnt !== 4'd1) begin fails++; $display("FAIL cap_cnt: got %0d want 1", trk_cnt); end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL cap_data: got %h want a5", data_out); end
        tests++; if (data_out_vld !== 1'b1) begin fails++; $display("FAIL cap_vld: got %b want 1", data_out_vld); end
        tests++; if (prop_signal !== 1'b1) begin fails++; $display("FAIL cap_prop: got %b want 1", prop_signal); end
        tick();
        idle();
        tests++; if (trk_state !== 2'd2) begin fails++; $display("FAIL cap_done: got %0d want 2", trk_state); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL cap_err: got %b want 0", err_sticky); end
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL cap_empty: got %b want 11", empty); end
    endtask

    task automatic test_interleave();
        int pch [7]  = '{0, 1, 0, 0, 1, 0, 1};
        int edat [7] = '{'h40, 'h11, 'h41, 'h42, 'h22, 'h43, 'h33};
        int evld [7] = '{0, 0, 0, 0, 0, 0, 1};
        int ecnt [7] = '{3, 2, 2, 2, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1); tick();
        tests++; if (trk_cnt !== 4'd3) begin fails++; $display("FAIL il_cnt0: got %0d want 3", trk_cnt); end
        tests++; if (trk_ch !== 1'b1) begin fails++; $display("FAIL il_ch: got %0d want 1", trk_ch); end
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, CHWID'(pch[i]), 1'b0);
            #1;
            tests++; if (data_out !== 8'(edat[i])) begin fails++; $display("FAIL il_data[%0d]: got %h want %h", i, data_out, 8'(edat[i])); end
            tests++; if (data_out_vld !== 1'(evld[i])) begin fails++; $display("FAIL il_vld[%0d]: got %b want %0d", i, data_out_vld, evld[i]); end
            tick();
            tests++; if (trk_cnt !== 4'(ecnt[i])) begin fails++; $display("FAIL il_cnt[%0d]: got %0d want %0d", i, trk_cnt, ecnt[i]); end
        end
        idle();
        tests++; if (trk_state !== 2'd2) begin fails++; $display("FAIL il_done: got %0d want 2", trk_state); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL il_err: got %b want 0", err_sticky); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        tests++; if (full !== 2'b01) begin fails++; $display("FAIL full_set: got %b want 01", full); end
        tests++; if (empty !== 2'b10) begin fails++; $display("FAIL full_empty: got %b want 10", empty); end
        drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        #1;
        tests++; if (data_out !== 8'h80) begin fails++; $display("FAIL full_head: got %h want 80", data_out); end
        tick();
        tests++; if (full[0] !== 1'b0) begin fails++; $display("FAIL full_clr: got %b want 0", full[0]); end
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            #1;
            tests++; if (data_out !== 8'(8'h80 + i)) begin fails++; $display("FAIL full_drain[%0d]: got %h want %h", i, data_out, 8'(8'h80 + i)); end
            tick();
        end
        idle();
        tests++; if (empty[0] !== 1'b1) begin fails++; $display("FAIL full_occ7: got %b want 1", empty[0]); end
    endtask

    task automatic test_corrupt();
        do_reset();
        drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tests++; if (trk_cnt !== 4'd1) begin fails++; $display("FAIL cor_cnt: got %0d want 1", trk_cnt); end
        mem_v = dut.mem_q;
        mem_v[1][0] = 8'h5B;
        force dut.mem_q = mem_v;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        tests++; if (data_out_vld !== 1'b1) begin fails++; $display("FAIL cor_vld: got %b want 1", data_out_vld); end
        tests++; if (prop_signal !== 1'b0) begin fails++; $display("FAIL cor_prop: got %b want 0", prop_signal); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL cor_err_early: got %b want 0", err_sticky); end
        tick();
        release dut.mem_q;
        idle();
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL cor_err: got %b want 1", err_sticky); end
        repeat (10) tick();
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL cor_err_hold: got %b want 1", err_sticky); end
        tests++; if (prop_signal !== 1'b1) begin fails++; $display("FAIL cor_prop_idle: got %b want 1", prop_signal); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1);
        tick();
        tests++; if (trk_cnt !== 4'd4) begin fails++; $display("FAIL rm_cnt: got %0d want 4", trk_cnt); end
        drive(1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        tests++; if (trk_state !== 2'd0) begin fails++; $display("FAIL rm_state: got %0d want 0", trk_state); end
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL rm_empty: got %b want 11", empty); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL rm_err: got %b want 0", err_sticky); end
        tests++; if (trk_cnt !== 4'd0) begin fails++; $display("FAIL rm_cnt0: got %0d want 0", trk_cnt); end
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tests++; if (trk_state !== 2'd1) begin fails++; $display("FAIL rm_recap: got %0d want 1", trk_state); end
        tests++; if (trk_ch !== 1'b1) begin fails++; $display("FAIL rm_ch: got %0d want 1", trk_ch); end
        tests++; if (trk_cnt !== 4'd1) begin fails++; $display("FAIL rm_cnt1: got %0d want 1", trk_cnt); end
    endtask

    task automatic test_capture_with_pop();
        do_reset();
        drive(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1); tick();
        tests++; if (trk_cnt !== 4'd2) begin fails++; $display("FAIL cwp_cnt: got %0d want 2", trk_cnt); end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        tests++; if (data_out !== 8'h11 || data_out_vld !== 1'b0) begin fails++; $display("FAIL cwp_pop1: got %h/%b want 11/0", data_out, data_out_vld); end
        tick();
        #1;
        tests++; if (data_out !== 8'h12 || data_out_vld !== 1'b1) begin fails++; $display("FAIL cwp_pop2: got %h/%b want 12/1", data_out, data_out_vld); end
        tick();
        idle();
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL cwp_err: got %b want 0", err_sticky); end
    endtask

`ifdef SB_RECAPTURE_EN
    task automatic test_back_to_back();
        logic [7:0] cdat [2] = '{8'h01, 8'h02};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, CHWID'(i), cdat[i], 1'b0, 1'b0, 1'b1);
            tick();
            drive(1'b0, 1'b0, 8'h00, 1'b1, CHWID'(i), 1'b0);
            #1;
            tests++; if (data_out_vld !== 1'b1 || data_out !== cdat[i]) begin fails++; $display("FAIL b2b_vld[%0d]: got %b/%h want 1/%h", i, data_out_vld, data_out, cdat[i]); end
            tick();
            idle();
            tests++; if (trk_state !== 2'd2) begin fails++; $display("FAIL b2b_done[%0d]: got %0d want 2", i, trk_state); end
            tick();
            tests++; if (trk_state !== 2'd0) begin fails++; $display("FAIL b2b_idle[%0d]: got %0d want 0", i, trk_state); end
            tests++; if (capture_count !== 16'(i + 1)) begin fails++; $display("FAIL b2b_cc[%0d]: got %0d want %0d", i, capture_count, i + 1); end
        end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL b2b_err: got %b want 0", err_sticky); end
    endtask
`else
    task automatic test_done_terminal();
        do_reset();
        drive(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1); tick();
        idle();
        repeat (3) tick();
        tests++; if (trk_state !== 2'd2) begin fails++; $display("FAIL done_hold: got %0d want 2", trk_state); end
        tests++; if (trk_ch !== 1'b0) begin fails++; $display("FAIL done_ch: got %0d want 0", trk_ch); end
        tests++; if (empty !== 2'b01) begin fails++; $display("FAIL done_push: got %b want 01", empty); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_capture();
        test_interleave();
        test_full();
        test_corrupt();
        test_reset_mid();
        test_capture_with_pop();
`ifdef SB_RECAPTURE_EN
        test_back_to_back();
`else
        test_done_terminal();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
